// File: rtl/uart_rx_frontend_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frontend_if
//  Description : FIFO write-port bundle between the UART receiver (master)
//                and the dual-clock FIFO write side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frontend_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_wr_en;
    logic                  fifo_full;

    // Receiver side: produces data and push strobe, observes full
    modport master (
        output fifo_wr_data,
        output fifo_wr_en,
        input  fifo_full
    );

    // FIFO side: consumes data and push strobe, reports full
    modport slave (
        input  fifo_wr_data,
        input  fifo_wr_en,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frontend
//  Description : Oversampling UART receiver on uart_clk. Deserialises 8N1
//                frames LSB first, pushes good bytes into the FIFO write port
//                and pulses framing / overrun (and optional parity) errors.
//                Optional macro UART_PARITY_EN adds an even-parity bit
//                between the data bits and the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
    parameter int CLK_FREQ   = 18_432_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic         uart_clk,
    input  wire logic         uart_rst_n,
    input  wire logic         rx_in,
    uart_rx_frontend_if.master fifo,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              parity_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int C_DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int C_SMP_W = $clog2(OVERSAMPLE);
    localparam int C_BIT_W = $clog2(DATA_WIDTH);

    localparam logic [C_DIV_W-1:0] C_DIV_LAST  = C_DIV_W'(C_DIV - 1);
    localparam logic [C_SMP_W-1:0] C_MID_START = C_SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [C_SMP_W-1:0] C_SMP_LAST  = C_SMP_W'(OVERSAMPLE - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_START  = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_PARITY = 3'd3;
    localparam logic [2:0] C_ST_STOP   = 3'd4;
    localparam logic [2:0] C_ST_BREAK  = 3'd5;

    // Elaboration-time configuration checks
    generate
        if (C_DIV < 1) begin : g_bad_div
            $error("uart_rx_frontend: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
            $error("uart_rx_frontend: OVERSAMPLE must be even and >= 8");
        end
        if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : g_bad_width
            $error("uart_rx_frontend: DATA_WIDTH must be 5..9");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [C_DIV_W-1:0]    r_div_cnt;
    logic [C_SMP_W-1:0]    r_smp_cnt;
    logic [C_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;

    logic                  w_tick;
    logic [C_SMP_W-1:0]    w_smp_target;
    logic                  w_mid;
    logic                  w_stop_mid;
    logic                  w_push_req;
    logic                  w_frame_req;
    logic                  w_overrun_req;
    logic                  w_parity_req;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Oversample tick and mid-bit detection. START waits half a bit, every
    // later bit waits a full bit from the previous mid-point.
    assign w_tick       = (r_state != C_ST_IDLE) && (r_div_cnt == C_DIV_LAST);
    assign w_smp_target = (r_state == C_ST_START) ? C_MID_START : C_SMP_LAST;
    assign w_mid        = w_tick && (r_smp_cnt == w_smp_target);

    // Divider and sample counters; held at zero in IDLE so START begins fresh
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
        end else if (r_state == C_ST_IDLE) begin
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : (r_div_cnt + C_DIV_W'(1));
            if (w_mid) begin
                r_smp_cnt <= '0;
            end else if (w_tick) begin
                r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
            end
        end
    end

    // Shift register and bit counter: LSB arrives first, so shift right
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == C_ST_IDLE) begin
            r_bit_cnt <= '0;
        end else if ((r_state == C_ST_DATA) && w_mid) begin
            r_shreg   <= {r_rx_s, r_shreg[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
        end
    end

`ifdef UART_PARITY_EN
    logic r_par_flag;

    // Parity mismatch flag: cleared per frame, set when the received parity
    // bit does not make the total count of ones even
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_par_flag <= 1'b0;
        end else if (r_state == C_ST_START) begin
            r_par_flag <= 1'b0;
        end else if ((r_state == C_ST_PARITY) && w_mid) begin
            r_par_flag <= (r_rx_s != (^r_shreg));
        end
    end
`endif

    // FSM state register
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (!r_rx_s) w_next_state = C_ST_START;
            end
            C_ST_START: begin
                if (w_mid) w_next_state = r_rx_s ? C_ST_IDLE : C_ST_DATA;
            end
            C_ST_DATA: begin
                if (w_mid && (r_bit_cnt == C_BIT_LAST)) begin
`ifdef UART_PARITY_EN
                    w_next_state = C_ST_PARITY;
`else
                    w_next_state = C_ST_STOP;
`endif
                end
            end
            C_ST_PARITY: begin
                if (w_mid) w_next_state = C_ST_STOP;
            end
            C_ST_STOP: begin
                if (w_mid) w_next_state = r_rx_s ? C_ST_IDLE : C_ST_BREAK;
            end
            C_ST_BREAK: begin
                if (r_rx_s) w_next_state = C_ST_IDLE;
            end
            default: w_next_state = C_ST_IDLE;
        endcase
    end

    // FSM output logic: stop-bit verdict and busy indication.
    // Frame error beats parity error, which beats the full/overrun decision.
    always_comb begin
        w_stop_mid    = (r_state == C_ST_STOP) && w_mid;
        w_frame_req   = w_stop_mid && !r_rx_s;
`ifdef UART_PARITY_EN
        w_parity_req  = w_stop_mid && r_rx_s && r_par_flag;
`else
        w_parity_req  = 1'b0;
`endif
        w_overrun_req = w_stop_mid && r_rx_s && !w_parity_req && fifo.fifo_full;
        w_push_req    = w_stop_mid && r_rx_s && !w_parity_req && !fifo.fifo_full;
        rx_busy       = (r_state == C_ST_START) || (r_state == C_ST_DATA) ||
                        (r_state == C_ST_PARITY) || (r_state == C_ST_STOP);
    end

    // Registered push strobe, data and error pulses; data only moves on push
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            fifo.fifo_wr_en   <= 1'b0;
            fifo.fifo_wr_data <= '0;
            frame_err         <= 1'b0;
            overrun_err       <= 1'b0;
        end else begin
            fifo.fifo_wr_en <= w_push_req;
            frame_err       <= w_frame_req;
            overrun_err     <= w_overrun_req;
            if (w_push_req) begin
                fifo.fifo_wr_data <= r_shreg;
            end
        end
    end

`ifdef UART_PARITY_EN
    // Registered parity error pulse
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_parity_req;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Oversampling UART receiver in the UART clock domain, directly upstream of the dual-clock FIFO write port.
- Deserialises 8N1 frames from the vending-machine serial link and pushes each good byte into the FIFO.
- Reports framing and overrun errors to the system status logic.
- Runs entirely on uart_clk; the FIFO handles the crossing into the system clock domain.

Parameters:
CLK_FREQ, 18_432_000, uart_clk frequency in Hz
BAUD_RATE, 115_200, line bit rate
OVERSAMPLE, 16, sample ticks per bit (even, >=8)
DATA_WIDTH, 8, data bits per frame (5..9)

Ports:
uart_clk  in  1  receiver clock
uart_rst_n  in  1  asynchronous, active-low reset
rx_in  in  1  raw serial line, idle high, asynchronous to uart_clk
fifo_wr_data  out  DATA_WIDTH  received byte, to FIFO wr_data
fifo_wr_en  out  1  one-cycle push strobe, to FIFO wr_en
fifo_full  in  1  FIFO wr_full
rx_busy  out  1  high while a frame is in progress (states START..STOP)
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun_err  out  1  one-cycle pulse: good byte dropped because fifo_full
parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 without UART_PARITY_EN)

Behaviour:
- Reset: one clock, uart_clk; asynchronous, active-low reset uart_rst_n.
  - All outputs 0, FSM IDLE, counters 0, shift register 0.
  - Synchroniser flops reset to 1 (line idle).
- Reset mid-frame aborts the frame with no write and no error pulse.
- Input sync: rx_in passes through a 2-flop synchroniser. All logic uses the synchronised value rx_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation; DIV<1 is a configuration error.
  - Divider counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - Counter runs only when FSM != IDLE and is cleared on entry to START.
- FSM states: IDLE, START, DATA, STOP, BREAK (plus PARITY, see Optional Feature).
  - IDLE: rx_s==0 -> START; clear tick and sample counters.
  - START: on tick OVERSAMPLE/2-1 (mid start bit), rx_s==0 -> DATA with sample counter reset; rx_s==1 -> IDLE (glitch reject, no error).
  - DATA: every OVERSAMPLE ticks, sample rx_s at mid-bit and shift in LSB first. After DATA_WIDTH bits -> STOP (or PARITY).
  - STOP, mid stop bit, rx_s==1:
    - fifo_full==0: next cycle fifo_wr_en=1 for exactly one cycle, with fifo_wr_data=byte.
    - fifo_full==1: overrun_err pulses instead, byte dropped.
    - Either way -> IDLE.
  - STOP, mid stop bit, rx_s==0: frame_err pulses, no write -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. A held-low line produces exactly one frame_err.
- fifo_full is sampled only at the stop-bit decision; it is ignored elsewhere.
- fifo_wr_data holds its value until the next push. It changes only in the cycle fifo_wr_en is asserted.
- A new start edge is recognised only in IDLE. Back-to-back frames need no extra idle time beyond the second half of the stop bit.
- Latency: fifo_wr_en rises 1 uart_clk after the mid-stop-bit tick, plus 2 cycles of synchroniser delay from the line.
- Error pulses and fifo_wr_en are mutually exclusive in any cycle.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - PARITY state inserted between DATA and STOP; samples one bit at mid-bit.
  - Even parity over DATA_WIDTH bits. Mismatch latches a flag.
  - At the stop bit, if the stop bit is good and the flag is set: parity_err pulses, no write, no overrun_err.
  - Frame error takes precedence over parity error.
- When undefined: 8N1 only, parity_err tied 0, no PARITY state.

Test Plan:
(defaults, DIV=10, bit period 160 cycles)
1. Send 0xA5 8N1, fifo_full=0 -> single fifo_wr_en pulse, fifo_wr_data=0xA5, no error pulses, rx_busy low afterwards.
2. Send 0x00, 0xFF, 0x3C back-to-back with 1 stop bit -> three pushes in order 0x00, 0xFF, 0x3C, each 1600 cycles apart.
3. Low glitch on rx_in of 40 cycles -> FSM returns to IDLE, no push, no error.
4. Send 0x55 with stop bit driven 0, then hold line low 2000 cycles -> exactly one frame_err pulse, no push; next 0x12 frame is received correctly.
5. fifo_full=1 during stop bit of 0x7E -> overrun_err pulse, fifo_wr_en stays 0; deassert fifo_full, send 0x81 -> pushed normally.
6. Assert uart_rst_n low mid-DATA of 0xC3 -> outputs 0 immediately, no push after release. With UART_PARITY_EN, 0x01 sent with parity bit 0 -> parity_err pulse, no push.
